// File: rtl/toy_bpu_l0btb_chk.sv
// L0 BTB prediction checker: queues L0 predictions in issue order and
// compares each against the resolved next-stage prediction. On a mismatch
// it issues a one-cycle update/redirect strobe and drops all in-flight entries.

package toy_pack;
  parameter int ADDR_WIDTH       = 32;
  parameter int BPU_OFFSET_WIDTH = 4;

  typedef struct packed {
    logic                        taken;
    logic [ADDR_WIDTH-1:0]       pred_pc;
    logic [ADDR_WIDTH-1:0]       tgt_pc;
    logic [BPU_OFFSET_WIDTH-1:0] offset;
    logic                        is_cext;
    logic                        carry;
    logic                        need_align;
  } bpu_pkg;
endpackage

module toy_bpu_l0btb_chk
  import toy_pack::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       l0_vld,
  input  bpu_pkg                     l0_pld,
  input  logic                       bp1_vld,
  input  bpu_pkg                     bp1_pld,
  input  logic                       be_flush,
  output logic                       fe_ctrl_chgflw_vld_o,
  output bpu_pkg                     fe_ctrl_chgflw_pld_o,
  output logic                       pcgen_stall,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_WIDTH-1:0]       mispred_cnt,
  output logic                       overflow_err
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t               state_q, state_d;
  logic [PW:0]          wr_ptr_q, wr_ptr_d;
  logic [PW:0]          rd_ptr_q, rd_ptr_d;
  logic                 strobe_q, strobe_d;
  bpu_pkg               pld_q, pld_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  bpu_pkg               mem_q [DEPTH];

  logic   full, empty, push, pop, mismatch;
  bpu_pkg head;

  // need_align only affects fetch alignment, so it never causes a redirect
  function automatic logic same_pred(bpu_pkg a, bpu_pkg b);
    a.need_align = 1'b0;
    b.need_align = 1'b0;
    return a == b;
  endfunction

  // Wrap bit in the pointers lets full and empty be told apart
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = occupancy == (PW+1)'(DEPTH);
  assign empty     = occupancy == '0;
  assign head      = mem_q[rd_ptr_q[PW-1:0]];

  // A flush in the strobe cycle cancels the already-registered update
  assign fe_ctrl_chgflw_vld_o = strobe_q & ~be_flush;
  assign fe_ctrl_chgflw_pld_o = pld_q;
  assign pcgen_stall          = full;
  assign mispred_cnt          = cnt_q;
  assign overflow_err         = ovf_q;

  // Next-state: flush > redirect squash > normal push/pop/compare
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    strobe_d = 1'b0;
    pld_d    = pld_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    pop      = 1'b0;
    mismatch = 1'b0;
    if (be_flush) begin
      state_d  = RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (state_q == REDIRECT) begin
      // Wrong-path cycle: inputs are ignored
      state_d = RUN;
    end else begin
      // An entry pushed into an empty FIFO is not visible to the same-cycle pop
      pop      = bp1_vld && !empty;
      mismatch = pop && !same_pred(head, bp1_pld);
      if (l0_vld && full) ovf_d = 1'b1;
      if (mismatch) begin
        state_d  = REDIRECT;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        strobe_d = 1'b1;
        pld_d    = bp1_pld;
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else begin
        push = l0_vld && !full;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      strobe_q <= 1'b0;
      pld_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      strobe_q <= strobe_d;
      pld_q    <= pld_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are meaningless outside the pointer window
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= l0_pld;
  end
endmodule

// File: tb/tb_toy_bpu_l0btb_chk.sv
// Directed bench for toy_bpu_l0btb_chk (DEPTH=4, CNT_WIDTH=4).
module tb_toy_bpu_l0btb_chk;
  import toy_pack::*;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   l0_vld = 1'b0, bp1_vld = 1'b0, be_flush = 1'b0;
  bpu_pkg                 l0_pld = '0, bp1_pld = '0;
  logic                   vld_o, stall, ovf;
  bpu_pkg                 pld_o;
  logic [$clog2(DEPTH):0] occ;
  logic [CNT_WIDTH-1:0]   cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  toy_bpu_l0btb_chk #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .l0_vld(l0_vld), .l0_pld(l0_pld),
    .bp1_vld(bp1_vld), .bp1_pld(bp1_pld),
    .be_flush(be_flush),
    .fe_ctrl_chgflw_vld_o(vld_o), .fe_ctrl_chgflw_pld_o(pld_o),
    .pcgen_stall(stall), .occupancy(occ),
    .mispred_cnt(cnt), .overflow_err(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bpu_pkg mk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bpu_pkg p;
    p            = '0;
    p.pred_pc    = pc;
    p.taken      = tk;
    p.tgt_pc     = tgt;
    p.offset     = pc[5:2];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    l0_vld = 1'b0; bp1_vld = 1'b0; be_flush = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_vld_o", vld_o, 0);
    chk("rst_pld_o", pld_o, 0);
    chk("rst_occ",   occ, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt",   cnt, 0);
    chk("rst_ovf",   ovf, 0);
    rst = 1'b0;

    // Three predictions confirmed by bp1; need_align difference is ignored
    for (int i = 0; i < 3; i++) begin
      l0_vld = 1'b1; l0_pld = mk(32'h100 + 32'(i*'h40), 1'b0, 32'h0);
      tick();
      chk("t1_push_occ", occ, i + 1);
    end
    l0_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bp1_vld = 1'b1; bp1_pld = mk(32'h100 + 32'(i*'h40), 1'b0, 32'h0);
      bp1_pld.need_align = (i == 1);
      tick();
      chk("t1_pop_occ", occ, 2 - i);
      chk("t1_no_strobe", vld_o, 0);
    end
    chk("t1_cnt", cnt, 0);
    idle();

    // Mismatch on taken: strobe at T+1 only, FIFO flushed, T and T+1 pushes dropped
    l0_vld = 1'b1; l0_pld = mk(32'h200, 1'b0, 32'h0);
    tick();
    chk("t2_occ_pre", occ, 1);
    l0_vld = 1'b1; l0_pld = mk(32'h204, 1'b0, 32'h0);
    bp1_vld = 1'b1; bp1_pld = mk(32'h200, 1'b1, 32'h2000);
    tick();
    chk("t2_vld_o", vld_o, 1);
    chk("t2_tgt", pld_o.tgt_pc, 32'h2000);
    chk("t2_taken", pld_o.taken, 1);
    chk("t2_occ", occ, 0);
    chk("t2_cnt", cnt, 1);
    bp1_vld = 1'b0;
    l0_vld = 1'b1; l0_pld = mk(32'h208, 1'b0, 32'h0);
    tick();
    chk("t2_vld_o_off", vld_o, 0);
    chk("t2_wrongpath_occ", occ, 0);
    chk("t2_pld_hold", pld_o.tgt_pc, 32'h2000);
    idle();

    // Fill to full, overflow, then one pop clears stall
    for (int i = 0; i < 4; i++) begin
      l0_vld = 1'b1; l0_pld = mk(32'h300 + 32'(i*4), 1'b0, 32'h0);
      tick();
    end
    chk("t3_full_occ", occ, 4);
    chk("t3_stall", stall, 1);
    chk("t3_ovf_pre", ovf, 0);
    l0_vld = 1'b1; l0_pld = mk(32'h3f0, 1'b0, 32'h0);
    tick();
    chk("t3_ovf", ovf, 1);
    chk("t3_occ_hold", occ, 4);
    l0_vld = 1'b0;
    bp1_vld = 1'b1; bp1_pld = mk(32'h300, 1'b0, 32'h0);
    #1;
    chk("t3_stall_with_pop", stall, 1);
    tick();
    chk("t3_stall_clr", stall, 0);
    chk("t3_occ3", occ, 3);
    for (int i = 1; i < 4; i++) begin
      bp1_pld = mk(32'h300 + 32'(i*4), 1'b0, 32'h0);
      tick();
      chk("t3_drain_strobe", vld_o, 0);
    end
    chk("t3_drained", occ, 0);
    idle();

    // Mismatch then flush at T+1 cancels strobe; counter still counts
    l0_vld = 1'b1; l0_pld = mk(32'h400, 1'b1, 32'h4400);
    tick();
    l0_vld = 1'b0;
    bp1_vld = 1'b1; bp1_pld = mk(32'h400, 1'b1, 32'h4800);
    tick();
    bp1_vld = 1'b0; be_flush = 1'b1;
    #1;
    chk("t4_cancel", vld_o, 0);
    tick();
    be_flush = 1'b0;
    chk("t4_cnt", cnt, 2);
    chk("t4_occ", occ, 0);
    // Flush with simultaneous push/pop
    l0_vld = 1'b1; l0_pld = mk(32'h500, 1'b0, 32'h0);
    tick();
    l0_vld = 1'b1; l0_pld = mk(32'h504, 1'b0, 32'h0);
    bp1_vld = 1'b1; bp1_pld = mk(32'h500, 1'b1, 32'h9999);
    be_flush = 1'b1;
    tick();
    idle();
    chk("t4_flush_occ", occ, 0);
    chk("t4_flush_cnt", cnt, 2);
    chk("t4_flush_ovf", ovf, 1);
    chk("t4_flush_vld", vld_o, 0);

    // bp1 on empty with same-cycle push: push kept, no compare
    l0_vld = 1'b1; l0_pld = mk(32'h600, 1'b0, 32'h0);
    bp1_vld = 1'b1; bp1_pld = mk(32'h7777, 1'b1, 32'h1);
    tick();
    chk("t5_empty_push_occ", occ, 1);
    chk("t5_empty_cnt", cnt, 2);
    // Simultaneous push/pop on non-empty keeps occupancy
    l0_vld = 1'b1; l0_pld = mk(32'h604, 1'b0, 32'h0);
    bp1_vld = 1'b1; bp1_pld = mk(32'h600, 1'b0, 32'h0);
    tick();
    chk("t5_pushpop_occ", occ, 1);
    chk("t5_pushpop_vld", vld_o, 0);
    l0_vld = 1'b0;
    bp1_pld = mk(32'h604, 1'b0, 32'h0);
    tick();
    chk("t5_final_occ", occ, 0);
    idle();

    // Counter saturation
    ecnt = 2;
    for (int i = 0; i < 20; i++) begin
      l0_vld = 1'b1; l0_pld = mk(32'h1000 + 32'(i*4), 1'b0, 32'h0);
      tick();
      l0_vld = 1'b0;
      bp1_vld = 1'b1; bp1_pld = mk(32'h1000 + 32'(i*4), 1'b1, 32'h8000);
      tick();
      bp1_vld = 1'b0;
      ecnt = (ecnt == 15) ? 15 : ecnt + 1;
      tick();
    end
    chk("t6_cnt_sat", cnt, ecnt);
    chk("t6_cnt_f", cnt, 4'hF);

    // Async reset while in REDIRECT
    l0_vld = 1'b1; l0_pld = mk(32'h900, 1'b0, 32'h0);
    tick();
    l0_vld = 1'b0;
    bp1_vld = 1'b1; bp1_pld = mk(32'h900, 1'b1, 32'h9900);
    tick();
    bp1_vld = 1'b0;
    chk("t7_pre_vld", vld_o, 1);
    rst = 1'b1;
    #1;
    chk("t7_rst_vld", vld_o, 0);
    chk("t7_rst_pld", pld_o, 0);
    chk("t7_rst_cnt", cnt, 0);
    chk("t7_rst_ovf", ovf, 0);
    chk("t7_rst_occ", occ, 0);
    chk("t7_rst_stall", stall, 0);
    #1;
    rst = 1'b0;
    l0_vld = 1'b1; l0_pld = mk(32'hA00, 1'b0, 32'h0);
    tick();
    idle();
    chk("t7_first_push", occ, 1);
    chk("t7_post_vld", vld_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/toy_bpu_l0btb_chk.md
TOY_BPU_L0BTB_CHK -- requirements
Module: toy_bpu_l0btb_chk

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning in-flight L0 prediction FIFO depth (power of two, >=2).
REQ-002 SHALL provide parameter CNT_WIDTH, default 16, meaning width of the mispredict counter.
REQ-003 SHALL take toy_pack parameters ADDR_WIDTH and BPU_OFFSET_WIDTH and type bpu_pkg {taken, pred_pc, tgt_pc, offset, is_cext, carry, need_align}.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 l0_vld  input  1  L0 BTB prediction valid, one per cycle.
REQ-008 l0_pld  input  bpu_pkg  L0 BTB prediction.
REQ-009 bp1_vld  input  1  resolved next-stage prediction valid, in L0 issue order.
REQ-010 bp1_pld  input  bpu_pkg  resolved next-stage prediction.
REQ-011 be_flush  input  1  backend redirect; kills all in-flight state.
REQ-012 fe_ctrl_chgflw_vld_o  output  1  L0 BTB update/redirect strobe.
REQ-013 fe_ctrl_chgflw_pld_o  output  bpu_pkg  update payload (corrected prediction).
REQ-014 pcgen_stall  output  1  FIFO full; PC gen must not present l0_vld.
REQ-015 occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.
REQ-016 mispred_cnt  output  CNT_WIDTH  saturating count of issued updates.
REQ-017 overflow_err  output  1  sticky: push attempted while full.

Function
REQ-018 SHALL push l0_pld into the FIFO tail on l0_vld when state is RUN and the FIFO is not full.
REQ-019 SHALL pop the FIFO head on bp1_vld and compare head vs bp1_pld on taken, pred_pc, tgt_pc, offset, is_cext, carry; need_align excluded.
REQ-020 SHALL treat any field difference as mismatch; a match SHALL only pop, with no output.
REQ-021 SHALL treat bp1_vld with empty FIFO (and no same-cycle push) as ignored: no pop, no update, no counter change.
REQ-022 SHALL on mismatch at cycle T drive fe_ctrl_chgflw_vld_o=1 at T+1 for exactly one cycle, with fe_ctrl_chgflw_pld_o = bp1_pld captured at T (taken=0 payload invalidates the L0 entry).
REQ-023 SHALL hold fe_ctrl_chgflw_pld_o stable when vld_o is 0 (last value, reset all-zero).
REQ-024 SHALL implement states RUN and REDIRECT; RUN->REDIRECT on mismatch; REDIRECT->RUN unconditionally after one cycle.
REQ-025 SHALL at mismatch cycle T discard all FIFO entries, including any push presented at T; occupancy=0 at T+1.
REQ-026 SHALL ignore l0_vld and bp1_vld while in REDIRECT (wrong-path, not pushed, not compared).
REQ-027 SHALL allow simultaneous push and pop in RUN; occupancy unchanged; when FIFO is empty the pushed entry is not compared in the same cycle.
REQ-028 SHALL assert pcgen_stall combinationally when occupancy==DEPTH; a pop in the same cycle does not deassert it.
REQ-029 SHALL on l0_vld while full drop the prediction and set overflow_err, which stays set until reset.
REQ-030 SHALL wrap read/write pointers modulo DEPTH with an extra wrap bit for full/empty detection.
REQ-031 SHALL increment mispred_cnt by 1 per mismatch, saturating at all-ones.
REQ-032 SHALL give be_flush highest priority: FIFO cleared, state RUN, pending T+1 strobe cancelled, same-cycle push/pop/compare suppressed; mispred_cnt and overflow_err unaffected.

Reset
REQ-033 SHALL on rst force: FIFO empty, pointers 0, state RUN, fe_ctrl_chgflw_vld_o=0, fe_ctrl_chgflw_pld_o=0, pcgen_stall=0, occupancy=0, mispred_cnt=0, overflow_err=0.
REQ-034 SHALL apply reset asynchronously mid-operation, discarding any pending redirect; first push accepted on the first clk edge after rst deasserts.

Verification
REQ-035 Push 3 predictions (pred_pc 0x100/0x140/0x180), bp1 returns identical -> no strobe, occupancy 3->0, mispred_cnt=0.
REQ-036 Head L0 taken=0, bp1 taken=1 tgt_pc=0x2000 at T -> vld_o=1 at T+1 only with pld.tgt_pc=0x2000 taken=1; occupancy=0 at T+1; l0_vld at T+1 not pushed; mispred_cnt=1.
REQ-037 Fill 4 entries -> pcgen_stall=1; extra l0_vld -> overflow_err=1, occupancy stays 4; one pop -> stall=0 next cycle.
REQ-038 Mismatch at T and be_flush at T+1 -> vld_o=0 at T+1 (cancelled); be_flush with simultaneous push/pop -> occupancy 0.
REQ-039 Force mispred_cnt to all-ones via 2^CNT_WIDTH mismatches (or CNT_WIDTH=4 build: 20 mismatches) -> value holds 0xF.
REQ-040 Assert rst while in REDIRECT -> all outputs zero immediately; release -> next l0_vld pushed, occupancy=1.
